cache_miss_sequencer: RTL

- Sequences the MEM-stage data cache (direct-mapped, write-back, 32-bit line) against a fixed-latency main memory.
- Hit: issues the cache write-enables for a store in the same cycle.
- Miss: stalls the pipeline, writes back a dirty victim, refills the line, and sets the valid and dirty bits.
- Also keeps saturating miss and writeback counters for performance debug.

---
 rtl/cache_miss_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cache_miss_sequencer.sv
// ---------------------------------------------------------------------------
// cache_miss_sequencer
//
// Sequences a direct-mapped, write-back data cache (one 32-bit word per line)
// in the MEM stage against a fixed-latency main memory.
//   - Load hit  : nothing driven, no stall.
//   - Store hit : cache write enables issued combinationally in the same cycle.
//   - Miss      : pipeline stalls, a dirty victim is written back (WB), the
//                 line is read from memory (RF) and written into the cache
//                 (FILL). The access then replays from IDLE as a hit.
//   - Saturating miss / writeback counters for performance debug.
//
// Handshake: there is no valid/ready pair here. req_valid qualifies the MEM
// stage request; stall is the back-pressure. While stall is high the pipeline
// holds the request stable up to and including MEM. Once WB or RF is entered
// the sequence always runs through FILL back to IDLE, regardless of the
// request inputs, so a flush cannot leave memory or cache half-updated.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req_valid           : MEM stage holds a load or store
//   req_write           : 1 = store, 0 = load
//   req_is_word         : access size, 1 = word, 0 = byte
//   cache_hit           : tag match and valid for the current address
//   cache_dirty         : indexed line is dirty
//   stall               : freezes PC and pipeline registers up to MEM
//   we_cache            : cache write enable
//   cache_input_type    : cache data source, 0 = memory data, 1 = rt_data
//   set_valid/set_dirty : valid/dirty bit values written with we_cache
//   is_word_cache       : size applied to the cache write
//   we_memory           : memory write enable
//   memory_address_type : 1 = victim writeback address, 0 = ALU address
//   busy                : FSM outside IDLE (state visibility for debug)
//   miss_count          : saturating count of misses
//   wb_count            : saturating count of writebacks
// ---------------------------------------------------------------------------
module cache_miss_sequencer #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             req_is_word,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  output logic             stall,
  output logic             we_cache,
  output logic             cache_input_type,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             is_word_cache,
  output logic             we_memory,
  output logic             memory_address_type,
  output logic             busy,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          miss_evt;
  logic          wb_evt;

  // State register, access counter and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (miss_evt && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + 1'b1;
      end
      if (wb_evt && (wb_count != {CNT_W{1'b1}})) begin
        wb_count <= wb_count + 1'b1;
      end
    end
  end

  // Next-state logic. cache_hit / cache_dirty only matter in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_evt  = 1'b0;
    wb_evt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !cache_hit) begin
          miss_evt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = cache_dirty ? WB : RF;
        end
      end
      WB: begin
        if (cnt == CNT_LAST) begin
          state_nxt = RF;
          cnt_nxt   = '0;
          wb_evt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RF: begin
        if (cnt == CNT_LAST) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FILL: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    stall               = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b0;
    set_valid           = 1'b0;
    set_dirty           = 1'b0;
    is_word_cache       = req_is_word;
    we_memory           = 1'b0;
    memory_address_type = 1'b0;
    busy                = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && cache_hit && req_write) begin
          // Store hit: write rt_data and mark the line dirty right away.
          we_cache         = 1'b1;
          cache_input_type = 1'b1;
          set_valid        = 1'b1;
          set_dirty        = 1'b1;
        end else if (req_valid && !cache_hit) begin
          stall = 1'b1;
        end
      end
      WB: begin
        stall               = 1'b1;
        we_memory           = 1'b1;
        memory_address_type = 1'b1;
        busy                = 1'b1;
      end
      RF: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      FILL: begin
        // Refill is always a whole line; the replay applies the store, if any.
        stall         = 1'b1;
        we_cache      = 1'b1;
        set_valid     = 1'b1;
        is_word_cache = 1'b1;
        busy          = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule
